// File: rtl/lfu_pkg.sv
// rtl/lfu_pkg.sv - shared FSM state type and default parameters for the LFU tracker
// No ports: package only.
package lfu_pkg;

  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_AGING     = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SCAN   = 2'd2,
    ST_EVICT  = 2'd3
  } state_t;

endpackage

// File: rtl/lfu_counter_bank.sv
// rtl/lfu_counter_bank.sv - per-slot saturating use counters with aging and clear
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   inc_en/idx    increment one slot (saturating, optional halving of all slots)
//   clr_en/idx    clear one slot
//   cnt           current counter values, one CNT_W field per slot
module lfu_counter_bank
  import lfu_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int AGING     = DEF_AGING,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              inc_en,
  input  logic [IDX_W-1:0]                  inc_idx,
  input  logic                              clr_en,
  input  logic [IDX_W-1:0]                  clr_idx,
  output logic [NUM_SLOTS-1:0][CNT_W-1:0]   cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   NS_EXT  = NUM_SLOTS[IDX_W:0];

  logic [NUM_SLOTS-1:0][CNT_W-1:0] cnt_d;
  logic                            inc_ok;
  logic                            clr_ok;
  logic                            age;

  // Indices at or above NUM_SLOTS are silently ignored.
  assign inc_ok = ({1'b0, inc_idx} < NS_EXT);
  assign clr_ok = ({1'b0, clr_idx} < NS_EXT);

  always_comb begin
    cnt_d = cnt;
    age   = 1'b0;
    if (inc_en && inc_ok) begin
      if (cnt[inc_idx] != CNT_MAX) begin
        cnt_d[inc_idx] = cnt[inc_idx] + CNT_ONE;
      end
      if ((AGING != 0) && (cnt_d[inc_idx] == CNT_MAX)) begin
        age = 1'b1;
      end
    end
    // Halving floors at 1 so a live slot never looks empty after aging.
    if (age) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (cnt_d[i] != '0) begin
          if ((cnt_d[i] >> 1) == '0) begin
            cnt_d[i] = CNT_ONE;
          end else begin
            cnt_d[i] = cnt_d[i] >> 1;
          end
        end
      end
    end
    if (clr_en && clr_ok) begin
      cnt_d[clr_idx] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/lfu_tracker.sv
// rtl/lfu_tracker.sv - least-frequently-used slot tracker with scan-based eviction
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   req_valid/idx   access request and slot index
//   req_ready       request accepted when high (IDLE only); busy is its inverse
//   occupied        bit i set when slot i counter is nonzero
//   evict_valid/idx one-cycle pulse naming the evicted slot
module lfu_tracker
  import lfu_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int AGING     = DEF_AGING,
  localparam int IDX_W    = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [IDX_W-1:0]     req_idx,
  output logic                 req_ready,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic                 evict_valid,
  output logic [IDX_W-1:0]     evict_idx,
  output logic                 busy
);

  localparam logic [IDX_W:0]   NS_EXT    = NUM_SLOTS[IDX_W:0];
  localparam logic [IDX_W-1:0] SCAN_LAST = IDX_W'(NUM_SLOTS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  state_t                          state_q;
  state_t                          state_d;
  logic [IDX_W-1:0]                last_idx;
  logic [IDX_W-1:0]                scan_idx;
  logic [IDX_W-1:0]                min_idx;
  logic [CNT_W-1:0]                min_val;
  logic                            min_found;
  logic [NUM_SLOTS-1:0][CNT_W-1:0] cnt;
  logic [NUM_SLOTS-1:0]            nz;
  logic [NUM_SLOTS-1:0]            upd_occ;
  logic                            last_ok;
  logic                            take;
  logic                            accept;

  lfu_counter_bank #(
    .NUM_SLOTS (NUM_SLOTS),
    .CNT_W     (CNT_W),
    .AGING     (AGING),
    .IDX_W     (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (state_q == ST_UPDATE),
    .inc_idx (last_idx),
    .clr_en  (state_q == ST_EVICT),
    .clr_idx (min_idx),
    .cnt     (cnt)
  );

  assign accept  = req_valid && req_ready;
  assign last_ok = ({1'b0, last_idx} < NS_EXT);

  // Occupancy as it will be after this UPDATE: the touched slot becomes
  // nonzero and aging never empties a slot, so no need to wait for the bank.
  always_comb begin
    nz = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      nz[i] = |cnt[i];
    end
    upd_occ = nz;
    if (last_ok) begin
      upd_occ[last_idx] = 1'b1;
    end
  end

  // Strict less-than keeps the earliest index on ties; last_idx is never a candidate.
  always_comb begin
    take = 1'b0;
    if (scan_idx != last_idx) begin
      take = !min_found || (cnt[scan_idx] < min_val);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_UPDATE;
      ST_UPDATE: state_d = (last_ok && (&upd_occ)) ? ST_SCAN : ST_IDLE;
      ST_SCAN:   if (scan_idx == SCAN_LAST) state_d = ST_EVICT;
      ST_EVICT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_idx    <= '0;
      scan_idx    <= '0;
      min_idx     <= '0;
      min_val     <= '0;
      min_found   <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      occupied    <= '0;
      evict_valid <= 1'b0;
      evict_idx   <= '0;
    end else begin
      req_ready   <= (state_d == ST_IDLE);
      busy        <= (state_d != ST_IDLE);
      occupied    <= nz;
      evict_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            last_idx <= req_idx;
          end
        end
        ST_UPDATE: begin
          scan_idx  <= '0;
          min_found <= 1'b0;
        end
        ST_SCAN: begin
          if (take) begin
            min_val   <= cnt[scan_idx];
            min_idx   <= scan_idx;
            min_found <= 1'b1;
          end
          if (scan_idx != SCAN_LAST) begin
            scan_idx <= scan_idx + IDX_ONE;
          end
        end
        ST_EVICT: begin
          evict_valid <= 1'b1;
          evict_idx   <= min_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfu_tracker.sv
// tb/tb_lfu_tracker.sv - directed self-checking bench for lfu_tracker (4 slots, 8-bit, aging)
module tb_lfu_tracker;
  import lfu_pkg::*;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_idx;
  logic       req_ready;
  logic [3:0] occupied;
  logic       evict_valid;
  logic [1:0] evict_idx;
  logic       busy;

  int total = 0;
  int bad   = 0;

  lfu_tracker #(
    .NUM_SLOTS (4),
    .CNT_W     (8),
    .AGING     (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_idx     (req_idx),
    .req_ready   (req_ready),
    .occupied    (occupied),
    .evict_valid (evict_valid),
    .evict_idx   (evict_idx),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    req_valid = 1'b0;
    req_idx = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  // lat counts edges after the accepting edge until req_ready is back;
  // ev_cyc is the edge count at which evict_valid was seen (-1 if never).
  task automatic do_access(input logic [1:0] idx, output int lat, output int ev_cyc,
                           output int ev_idx);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    req_valid = 1'b1;
    req_idx = idx;
    tick();
    req_valid = 1'b0;
    lat = 0;
    ev_cyc = -1;
    ev_idx = -1;
    while (!req_ready && lat < 50) begin
      tick();
      lat++;
      if (evict_valid) begin
        ev_cyc = lat;
        ev_idx = int'(evict_idx);
      end
    end
  endtask

  int lat, ev_cyc, ev_idx;
  int seen_ev;

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    req_idx = '0;
    #22;
    rst = 1'b1;
    tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_occ", occupied, 4'b0000);

    // Asynchronous reset mid-cycle while busy.
    do_access(2'd0, lat, ev_cyc, ev_idx);
    tick();
    chk("pre_occ", occupied, 4'b0001);
    req_valid = 1'b1;
    req_idx = 2'd1;
    tick();
    req_valid = 1'b0;
    chk("pre_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_occ", occupied, 4'b0000);
    chk("arst_ready", req_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_ev", evict_valid, 0);
    chk("arst_evidx", evict_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Partial fill: no eviction, one-cycle turnaround.
    for (int s = 0; s < 3; s++) begin
      do_access(2'(s), lat, ev_cyc, ev_idx);
      chk("fill_lat", lat, 1);
      chk("fill_noev", ev_cyc, -1);
      tick();
      chk("fill_occ", occupied, (4'b0001 << (s + 1)) - 4'b0001);
    end

    // Counts {3,1,2,0}; touching slot 3 evicts slot 1.
    do_access(2'd0, lat, ev_cyc, ev_idx);
    do_access(2'd0, lat, ev_cyc, ev_idx);
    do_access(2'd2, lat, ev_cyc, ev_idx);
    chk("ev_pre_c0", dut.cnt[0], 3);
    chk("ev_pre_c2", dut.cnt[2], 2);
    do_access(2'd3, lat, ev_cyc, ev_idx);
    chk("ev_lat", lat, 6);
    chk("ev_cyc", ev_cyc, 6);
    chk("ev_idx", ev_idx, 1);
    tick();
    chk("ev_occ", occupied, 4'b1101);
    chk("ev_c1", dut.cnt[1], 0);
    chk("ev_c3", dut.cnt[3], 1);

    // Tie among 0..2 with slot 3 excluded as last accessed.
    reset_dut();
    for (int s = 0; s < 4; s++) begin
      do_access(2'(s), lat, ev_cyc, ev_idx);
    end
    chk("tie_lat", lat, 6);
    chk("tie_idx", ev_idx, 0);
    tick();
    chk("tie_occ", occupied, 4'b1110);

    // Reset during the second SCAN cycle: counts are {0,1,1,1}, touch slot 0.
    req_valid = 1'b1;
    req_idx = 2'd0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("ms_scan1", 32'(dut.state_q), 32'(ST_SCAN));
    tick();
    chk("ms_scan2", 32'(dut.state_q), 32'(ST_SCAN));
    #2 rst = 1'b0;
    #1;
    chk("ms_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("ms_ready", req_ready, 1);
    seen_ev = 0;
    repeat (3) begin
      tick();
      if (evict_valid) seen_ev++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (8) begin
      tick();
      if (evict_valid) seen_ev++;
    end
    chk("ms_noev", seen_ev, 0);
    for (int s = 0; s < 4; s++) begin
      chk("ms_cnt", dut.cnt[s], 0);
    end
    chk("ms_occ", occupied, 4'b0000);

    // Requests held while busy are dropped, not queued.
    for (int s = 0; s < 3; s++) begin
      do_access(2'(s), lat, ev_cyc, ev_idx);
    end
    req_valid = 1'b1;
    req_idx = 2'd3;
    tick();
    req_idx = 2'd1;
    lat = 0;
    ev_idx = -1;
    while (lat < 50) begin
      tick();
      lat++;
      if (evict_valid) ev_idx = int'(evict_idx);
      if (req_ready) break;
    end
    req_valid = 1'b0;
    chk("ign_lat", lat, 6);
    chk("ign_evidx", ev_idx, 0);
    chk("ign_c1", dut.cnt[1], 1);
    chk("ign_c3", dut.cnt[3], 1);
    tick();
    chk("ign_occ", occupied, 4'b1110);

    // Aging: slot0 at 254, slots 1,2 at 1, then one more access to slot 0.
    reset_dut();
    do_access(2'd1, lat, ev_cyc, ev_idx);
    do_access(2'd2, lat, ev_cyc, ev_idx);
    for (int k = 0; k < 254; k++) begin
      do_access(2'd0, lat, ev_cyc, ev_idx);
    end
    chk("age_pre_c0", dut.cnt[0], 254);
    tick();
    chk("age_pre_occ", occupied, 4'b0111);
    do_access(2'd0, lat, ev_cyc, ev_idx);
    chk("age_lat", lat, 1);
    chk("age_noev", ev_cyc, -1);
    chk("age_c0", dut.cnt[0], 127);
    chk("age_c1", dut.cnt[1], 1);
    chk("age_c2", dut.cnt[2], 1);
    chk("age_c3", dut.cnt[3], 0);
    tick();
    chk("age_occ", occupied, 4'b0111);
    do_access(2'd0, lat, ev_cyc, ev_idx);
    chk("age_post_c0", dut.cnt[0], 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
